uart_rx: RTL

UART receiver for the SoC's UART0 port: it recovers 8N1 bytes from the asynchronous `soc_uart0_rx` pin and presents them to the SoC bus side through a single-entry valid/ready holding register. It is the receive-direction counterpart of the existing UART transmit path and shares its baud configuration. Framing errors and overruns are flagged as one-cycle pulses for the SoC status register.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, oversampling rate and baud divider helper.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_RATE = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick divider: one-cycle tick every CLK_HZ/(BAUD*OVERSAMPLE) clocks, with synchronous clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_RATE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, majority voting and a single-entry valid/ready holding
// register. Framing errors and overruns are reported as registered one-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_RATE
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] settle_q;
  rx_state_e  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       tick, start_edge, vote, complete, clr_tick;

  // The synchroniser is forced high by reset; ignore edges until it has flushed so a line that
  // is already low after reset is not mistaken for a start bit.
  assign start_edge = prev_q & ~sync2_q & (&settle_q);
  // 2-of-3 vote: samples taken at ticks 7 and 8 plus the live line at tick 9
  assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync2_q) | (samp_q[0] & sync2_q);
  assign clr_tick = (state_q == StIdle) && start_edge;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_tick),
    .tick_o(tick)
  );

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    complete    = 1'b0;
    frame_err_d = 1'b0;

    if (tick && (state_q inside {StStart, StData, StStop})) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
    end
    if (tick && ((tick_cnt_q == 4'd7) || (tick_cnt_q == 4'd8))) begin
      samp_d = {samp_q[0], sync2_q};
    end

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d    = StStart;
          tick_cnt_d = '0;
        end
      end
      StStart: begin
        // Mid-bit check rejects glitches; the data phase starts on the start bit's 16th tick,
        // where tick_cnt wraps to 0, keeping every later sample window mid-bit.
        if (tick && (tick_cnt_q == 4'd7) && sync2_q) begin
          state_d = StIdle;
        end else if (tick && (tick_cnt_q == 4'd15)) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (tick && (tick_cnt_q == 4'd9)) begin
          shift_d = {vote, shift_q[7:1]};
        end
        if (tick && (tick_cnt_q == 4'd15)) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick && (tick_cnt_q == 4'd9)) begin
          if (vote) begin
            complete = 1'b1;
            state_d  = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (sync2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (complete) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      settle_q    <= '0;
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      settle_q    <= (&settle_q) ? settle_q : settle_q + 2'd1;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
